// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t   : sequencer FSM encoding (3 bits)
//   params_ok : elaboration-time range check for the sequencer parameters
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SWRST     = 3'd4
    } state_t;

    // Both intervals must fit the counter: the counter counts 0 .. interval-1.
    function automatic bit params_ok(int n_domains, int hold_cycles,
                                     int step_cycles, int cnt_w);
        longint lim;
        lim = longint'(1) << cnt_w;
        return (n_domains >= 1) && (hold_cycles >= 1) && (step_cycles >= 1) &&
               (longint'(hold_cycles) <= lim) && (longint'(step_cycles) <= lim);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into clk.
// Ports:
//   clk   in  destination clock
//   rst   in  async active-high reset, flops load RST_VAL
//   d     in  asynchronous input
//   q     out synchronised output (2 clk cycles latency)
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= {WIDTH{RST_VAL}};
            q    <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Central reset sequencer for the clock tree.
// Holds every reset domain asserted until the PLL is locked, waits HOLD_CYCLES,
// then releases domains one at a time in ascending index, STEP_CYCLES apart.
// Lock loss or a software reset request re-asserts all domains together and
// restarts the sequence.
// Ports:
//   clk         in  system clock
//   rst         in  async active-high reset
//   pll_locked  in  PLL lock (asynchronous, synchronised internally)
//   sw_rst_req  in  software reset request, level, clk domain
//   sw_rst_ack  out software reset acknowledge (4-phase handshake)
//   rst_out     out per-domain active-high resets, registered
//   ready       out high only when all domains are released
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 sw_rst_req,
    output logic                 sw_rst_ack,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready
);

    if (!params_ok(N_DOMAINS, HOLD_CYCLES, STEP_CYCLES, CNT_W)) begin : g_bad_params
        $error("rst_sequencer: parameter out of range");
    end

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOMAINS - 1);

    logic locked_s;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                 ready_q, ready_d;
    logic                 ack_q, ack_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        ack_d     = ack_q;

        // Lock loss outranks everything, including an expiring counter and a
        // pending software request; it also aborts an open handshake.
        if (state_q != ST_WAIT_LOCK && !locked_s) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            ack_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_WAIT_LOCK: begin
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    ack_d     = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    if (locked_s) state_d = ST_HOLD;
                end

                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        if (N_DOMAINS == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        for (int k = 0; k < N_DOMAINS; k++)
                            if (idx_q == IDX_W'(k)) rst_out_d[k] = 1'b0;
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    if (sw_rst_req) begin
                        state_d   = ST_SWRST;
                        rst_out_d = '1;
                        ready_d   = 1'b0;
                        ack_d     = 1'b1;
                    end
                end

                ST_SWRST: begin
                    rst_out_d = '1;
                    // Lock is still valid here, so the lock wait is skipped.
                    if (!sw_rst_req) begin
                        state_d = ST_HOLD;
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end

                default: begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    ack_d     = 1'b0;
                end
            endcase
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign sw_rst_ack = ack_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Central reset controller for the FPGA clock tree.
- Holds all downstream reset domains asserted until the PLL reports lock, waits a guard interval, then releases the domains one at a time in index order, spaced by a fixed step.
- Re-runs the sequence on PLL lock loss or on a software reset request, the latter using a 4-phase handshake.
- Outputs are registered in clk and feed the per-domain reset bridges, which provide async-assert / sync-deassert in each target clock.

Parameters:
- N_DOMAINS, 3: number of sequenced reset outputs (>=1).
- HOLD_CYCLES, 16: clk cycles from sequence start to release of domain 0 (>=1).
- STEP_CYCLES, 8: clk cycles between successive domain releases (>=1).
- CNT_W, 8: counter width; HOLD_CYCLES and STEP_CYCLES must both be <= 2**CNT_W; elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pll_locked  in  1  PLL lock, asynchronous to clk; 2-FF synchronised internally.
- sw_rst_req  in  1  software reset request, level, clk domain.
- sw_rst_ack  out  1  software reset acknowledge.
- rst_out  out  N_DOMAINS  per-domain reset, active-high, registered.
- ready  out  1  high only when all domains are released (state RUN).

Behaviour:
- Reset (rst=1, async):
  - rst_out = all 1s, ready = 0, sw_rst_ack = 0.
  - State WAIT_LOCK, counter cleared, synchroniser flops cleared to 0.
  - Power-on register values are identical.
- locked_s is pll_locked after 2 clk flops (2-cycle latency).
- States:
  - WAIT_LOCK: all rst_out = 1. When locked_s = 1, next edge -> HOLD with cnt = 0.
  - HOLD: cnt increments each cycle. When cnt == HOLD_CYCLES-1, next edge clears rst_out[0], sets cnt = 0, idx = 1, and goes -> RELEASE. If N_DOMAINS = 1 it goes -> RUN with ready <= 1 instead.
  - RELEASE: cnt increments. When cnt == STEP_CYCLES-1, next edge clears rst_out[idx], sets cnt = 0, idx += 1. If idx was N_DOMAINS-1, it goes -> RUN with ready <= 1 on the same edge.
  - RUN: outputs stable. If sw_rst_req = 1, next edge sets rst_out = all 1s, ready = 0, sw_rst_ack = 1, and goes -> SWRST.
  - SWRST: all rst_out = 1, sw_rst_ack = 1 while sw_rst_req = 1. On sw_rst_req = 0, next edge sets sw_rst_ack = 0 and goes -> HOLD with cnt = 0. Lock wait is skipped because lock is still valid.
- Timing from HOLD entry edge E:
  - rst_out[0] falls at E + HOLD_CYCLES.
  - rst_out[k] falls at E + HOLD_CYCLES + k*STEP_CYCLES.
  - ready rises together with rst_out[N_DOMAINS-1].
- Release order is strictly ascending index. Assertion is always all domains at once, on the same edge.
- Lock loss: locked_s = 0 in any state other than WAIT_LOCK.
  - Next edge sets rst_out = all 1s, ready = 0, sw_rst_ack = 0, and goes -> WAIT_LOCK.
  - Lock loss has priority over sw_rst_req and over counter expiry on the same cycle.
  - Lock loss during SWRST aborts the handshake: ack drops even if req is still high. Requester sees ack fall and must drop req. A req still high when RUN is next reached starts a new handshake.
- sw_rst_req outside RUN/SWRST is ignored. It is not latched; because it is a level, it is acted on once RUN is reached.
- A lock glitch shorter than 1 clk may be missed. This is acceptable; a glitch that is caught restarts the full sequence.
- No combinational path from any input to any output.

Decomposition:
- Shared package rst_seq_pkg holds:
  - state encoding localparams ST_WAIT_LOCK, ST_HOLD, ST_RELEASE, ST_RUN, ST_SWRST (3 bits);
  - the parameter-range check function.
- One sub-module: sync_2ff (2-flop synchroniser, parameterised reset value 0), instantiated for pll_locked.
- Counter and idx live inline in the FSM.

Test Plan:
- Power-up, defaults (3/16/8): pll_locked rises at cycle 10 -> HOLD entry at edge 12 (2-cycle sync). rst_out goes 111 -> 110 at 28, 100 at 36, 000 at 44. ready = 1 at 44. sw_rst_ack stays 0 throughout.
- Lock loss mid-RELEASE: drop pll_locked while rst_out = 110 -> 2 sync cycles later rst_out = 111 and ready = 0 on one edge, state WAIT_LOCK. Relock -> full sequence again with identical 16/8 spacing.
- Software reset in RUN: assert sw_rst_req -> next edge rst_out = 111, ack = 1, ready = 0. Hold req 20 cycles -> ack stays 1, rst_out stays 111. Drop req -> ack = 0 next edge, then releases at +16 / +24 / +32.
- Simultaneous events: lock loss on the cycle HOLD cnt = 15 with sw_rst_req = 1 -> rst_out[0] stays 1, state WAIT_LOCK, ack stays 0.
- Async rst mid-sequence: pulse rst for half a cycle while rst_out = 100 -> rst_out = 111 and ready = 0 immediately (no clock). Sequence restarts from WAIT_LOCK after the 2-cycle resync.
- N_DOMAINS = 1, HOLD_CYCLES = 1: lock -> rst_out falls 1 cycle after HOLD entry, ready rises same edge. Out-of-range STEP_CYCLES = 300 with CNT_W = 8 -> elaboration fails.
